dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Multi-cycle data-memory responder at the far end of the EX/DM stage memory interface.
- Accepts the pipeline's read/write strobes, address and store data, and holds the pipeline with a stall while a programmable number of wait states elapses.
- Commits stores and returns load data registered for the DM/WB buffer.
- Replaces the single-cycle data memory in the DM stage.

Parameters:
- ADDR_WIDTH, 8, word-index width; memory depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_ctrl  input  1  load request strobe from the EX/DM buffer.
- wd_ctrl  input  1  store request strobe from the EX/DM buffer.
- addr  input  32  byte address; this is the ALU result.
- wdata  input  32  store data, already forwarded.
- rdata  output  32  registered load data.
- stall  output  1  combinational hold request to the PC, IF/ID, ID/EX and EX/DM stages.
- done  output  1  one-cycle pulse marking the response cycle.
- err  output  1  one-cycle registered pulse on an illegal request.

Behaviour:
- Reset:
  - state=IDLE, counter=0, rdata=0, done=0, err=0, captured address/data/op cleared.
  - Memory array contents are not reset.
  - stall=0 while rst is high.
- Word index is addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so accesses alias modulo depth.
- Legal request: exactly one of rd_ctrl/wd_ctrl is high and addr[1:0]==0.
- Illegal request: both strobes high, or either strobe high with addr[1:0]!=0.
  - Accepted only in IDLE.
  - No memory access, no stall, rdata unchanged.
  - err=1 in the following cycle for one cycle; state stays IDLE.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Legal request present: stall=1 in the same cycle (combinational).
  - At the clock edge, capture op, index and wdata; load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - stall=1; the counter decrements each cycle.
  - Strobe and address changes are ignored because the captured values are used.
  - When counter==1 at a clock edge, go to RESP and, in the same edge:
    - store: write the captured wdata to mem[index];
    - load: register mem[index] into rdata.
  - For WAIT_CYCLES=0 the same commit happens on the IDLE->RESP edge.
- RESP:
  - stall=0, done=1.
  - The pipeline advances at the end of this cycle.
  - Unconditional return to IDLE; no new request is accepted in RESP.
- Latency:
  - Request seen in IDLE at cycle T produces RESP at T+WAIT_CYCLES+1.
  - stall is high for cycles T..T+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles.
  - Load data is valid on rdata from the RESP cycle onward.
- rdata holds its value until the next legal load completes; stores never change rdata.
- Back-to-back: a request presented in the cycle after RESP is accepted normally in IDLE.
- Reset mid-operation (in WAIT): request is aborted, no write occurs, state returns to IDLE. A write already committed before reset is retained.
- Read of an address stored by the immediately preceding request returns the new data, because the commit is complete before the next IDLE.

Test Plan:
1. WAIT_CYCLES=2: store wdata=0xDEADBEEF at addr=0x10 → stall high 3 cycles, done pulses once at cycle T+3, err=0. Then load from 0x10 → rdata=0xDEADBEEF at T'+3.
2. WAIT_CYCLES=0: store 0x12345678 at 0x04, then load 0x04 in the cycle after done → stall high 1 cycle for each request, rdata=0x12345678 in the second RESP cycle.
3. Misaligned load addr=0x13, then rd_ctrl=wd_ctrl=1 at addr=0x20 → stall=0 both times, err pulses in each following cycle, rdata unchanged, mem[8] unchanged.
4. ADDR_WIDTH=8: store 0xA5A5A5A5 at addr=0x0000_0400 → load from 0x0 returns 0xA5A5A5A5 (aliasing).
5. Store 0x11111111 at 0x08; then start a store of 0x22222222 to 0x08, assert rst during WAIT; after release, load 0x08 → rdata=0x11111111, no done pulse for the aborted request, done=0/err=0/rdata=0 immediately on rst.
6. Change addr/wdata every cycle during WAIT of a store to 0x0C with data 0x0BADF00D → load 0x0C returns 0x0BADF00D.

Source files
------------

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder that replaces the single-cycle DM memory.
// Ports: clk/rst, rd_ctrl/wd_ctrl/addr/wdata request in; rdata/stall/done/err out.
module dm_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_ctrl,
  input  logic        wd_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  localparam bit         ZW = (WAIT_CYCLES == 0);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  op_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  done_q;
  logic                  err_q;
  logic [31:0]           mem_q [2**ADDR_WIDTH];

  logic                  req;
  logic                  legal;
  logic                  illegal;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic                  commit;
  logic                  c_st;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [31:0]           c_wdata;
  logic                  unused_addr;

  assign req         = rd_ctrl | wd_ctrl;
  assign legal       = (rd_ctrl ^ wd_ctrl) && (addr[1:0] == 2'b00);
  assign illegal     = req && !legal;
  assign in_idx      = addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  // With zero wait states the commit happens on the accepting edge,
  // so it must use the live request rather than the captured one.
  always_comb begin
    commit  = 1'b0;
    c_st    = op_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    if (state_q == IDLE && legal && ZW) begin
      commit  = 1'b1;
      c_st    = wd_ctrl;
      c_idx   = in_idx;
      c_wdata = wdata;
    end else if (state_q == WAIT && cnt_q == 4'd1) begin
      commit = 1'b1;
    end
  end

  assign stall = !rst &&
                 ((state_q == IDLE && legal) || state_q == WAIT);
  assign rdata = rdata_q;
  assign done  = done_q;
  assign err   = err_q;

  // Storage is not reset; a reset on the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_st) mem_q[c_idx] <= c_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= commit;
      err_q  <= (state_q == IDLE) && illegal;
      if (commit && !c_st) rdata_q <= mem_q[c_idx];
      unique case (state_q)
        IDLE: begin
          if (legal) begin
            op_q    <= wd_ctrl;
            idx_q   <= in_idx;
            wdata_q <= wdata;
            cnt_q   <= WC;
            state_q <= ZW ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: one instance with two wait states
// and one with none, driven by directed steps with an rdata scoreboard.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd   [2];
  logic        wd   [2];
  logic [31:0] ad   [2];
  logic [31:0] wdd  [2];
  logic [31:0] rdat [2];
  logic        stl  [2];
  logic        dn   [2];
  logic        er   [2];

  logic [31:0] mdl  [2][256];
  logic [31:0] rexp [2];
  logic [31:0] sb   [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst),
    .rd_ctrl(rd[0]), .wd_ctrl(wd[0]),
    .addr(ad[0]), .wdata(wdd[0]),
    .rdata(rdat[0]), .stall(stl[0]),
    .done(dn[0]), .err(er[0])
  );

  dm_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .rd_ctrl(rd[1]), .wd_ctrl(wd[1]),
    .addr(ad[1]), .wdata(wdd[1]),
    .rdata(rdat[1]), .stall(stl[1]),
    .done(dn[1]), .err(er[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Legal request; k=0 has two wait states, k=1 has none.
  task automatic req(input int k, input bit r, input bit w,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit chg);
    int lat;
    int stalls;
    int at;
    bit seen;
    logic [31:0] e;
    lat = (k == 0) ? 2 : 0;
    if (w) mdl[k][a[9:2]] = d;
    else rexp[k] = mdl[k][a[9:2]];
    sb.push_back(rexp[k]);
    @(posedge clk); #1;
    rd[k] = r; wd[k] = w; ad[k] = a; wdd[k] = d;
    stalls = 0; seen = 0; at = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stl[k] === 1'b1) stalls++;
      if (dn[k] === 1'b1) begin
        seen = 1; at = c;
        break;
      end
      @(posedge clk); #1;
      rd[k] = 0; wd[k] = 0;
      if (chg) begin
        ad[k]  = $urandom;
        wdd[k] = $urandom;
      end
    end
    chk($sformatf("done_seen k%0d a%h", k, a), 32'(seen), 32'd1);
    chk($sformatf("latency k%0d a%h", k, a), 32'(at), 32'(lat + 1));
    chk($sformatf("stall_cycles k%0d a%h", k, a),
        32'(stalls), 32'(lat + 1));
    chk($sformatf("err_at_done k%0d", k), 32'(er[k]), 32'd0);
    e = sb.pop_front();
    chk($sformatf("rdata k%0d a%h", k, a), rdat[k], e);
  endtask

  task automatic ill(input int k, input bit r, input bit w,
                     input logic [31:0] a);
    @(posedge clk); #1;
    rd[k] = r; wd[k] = w; ad[k] = a; wdd[k] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk($sformatf("ill_stall k%0d a%h", k, a), 32'(stl[k]), 32'd0);
    @(posedge clk); #1;
    rd[k] = 0; wd[k] = 0;
    @(negedge clk);
    chk($sformatf("ill_err k%0d a%h", k, a), 32'(er[k]), 32'd1);
    chk($sformatf("ill_rdata k%0d", k), rdat[k], rexp[k]);
    chk($sformatf("ill_done k%0d", k), 32'(dn[k]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("ill_err_pulse k%0d", k), 32'(er[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b1; wd[k] = 1'b0; ad[k] = 32'h0; wdd[k] = 32'h0;
      rexp[k] = 32'h0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_stall k%0d", k), 32'(stl[k]), 32'd0);
      chk($sformatf("rst_done k%0d", k), 32'(dn[k]), 32'd0);
      chk($sformatf("rst_err k%0d", k), 32'(er[k]), 32'd0);
      chk($sformatf("rst_rdata k%0d", k), rdat[k], 32'd0);
      rd[k] = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Store then load with two wait states; done is a single pulse.
    req(0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
    @(negedge clk);
    chk("done_pulse_width", 32'(dn[0]), 32'd0);
    req(0, 1, 0, 32'h10, 32'h0, 0);

    // Zero wait states, load back-to-back after the store.
    req(1, 0, 1, 32'h04, 32'h12345678, 0);
    req(1, 1, 0, 32'h04, 32'h0, 0);

    // Illegal requests leave mem[8] and rdata alone.
    req(0, 0, 1, 32'h20, 32'h5555AAAA, 0);
    ill(0, 1, 0, 32'h13);
    ill(0, 1, 1, 32'h20);
    req(0, 1, 0, 32'h20, 32'h0, 0);

    // Upper address bits alias.
    req(0, 0, 1, 32'h0000_0400, 32'hA5A5A5A5, 0);
    req(0, 1, 0, 32'h0, 32'h0, 0);
    req(1, 0, 1, 32'h0000_0400, 32'hA5A5A5A5, 0);
    req(1, 1, 0, 32'h0, 32'h0, 0);

    // Inputs wander while a store waits; captured values win.
    req(0, 0, 1, 32'h0C, 32'h0BADF00D, 1);
    req(0, 1, 0, 32'h0C, 32'h0, 0);

    // Reset during WAIT aborts the store.
    req(0, 0, 1, 32'h08, 32'h11111111, 0);
    @(posedge clk); #1;
    wd[0] = 1; ad[0] = 32'h08; wdd[0] = 32'h22222222;
    @(posedge clk); #1;
    wd[0] = 0;
    @(negedge clk);
    chk("wait_stall", 32'(stl[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_done", 32'(dn[0]), 32'd0);
    chk("midrst_err", 32'(er[0]), 32'd0);
    chk("midrst_rdata", rdat[0], 32'd0);
    chk("midrst_stall", 32'(stl[0]), 32'd0);
    rexp[0] = 32'h0;
    rexp[1] = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("no_done_after_abort c%0d", c), 32'(dn[0]), 32'd0);
    end
    req(0, 1, 0, 32'h08, 32'h0, 0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
